gate_vector_sequencer: RTL and testbench

- Self-checking controller that drives a 3-input combinational gate (xor3/and3 family) through all 8 input vectors in ascending order.
- Holds each vector for a programmable dwell and samples the gate output at the end of the dwell.
- Compares each sample against a truth-table parameter and reports pass/fail, error count and the first failing vector.
- Sits between the board's start button / LEDs and the gate under test on the IceZUM Alhambra (12 MHz).

---
 rtl/gate_vector_sequencer.sv | 125 ++++++++++++
 tb/tb_gate_vector_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_sequencer.sv
// Steps a 3-input gate through vectors 000..111 and checks each sampled z0 against EXPECTED.
// Latency 8*DWELL cycles from start to done. No backpressure: start is ignored while busy.
module gate_vector_sequencer #(
    parameter int unsigned DWELL    = 4,
    parameter logic [7:0]  EXPECTED = 8'h96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z0,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    localparam int unsigned   CW   = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    x_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [3:0]    err_count_q;
    logic          fail_valid_q;
    logic [2:0]    first_fail_q;

    logic          sample_now;
    logic          mismatch;
    logic [3:0]    err_count_d;

    // z0 is combinational from the registered vector, so it is settled by the last dwell cycle.
    always_comb begin
        sample_now  = (state_q == RUN) && (cnt_q == LAST);
        mismatch    = sample_now && (z0 != EXPECTED[idx_q]);
        err_count_d = err_count_q;
        if (mismatch && (err_count_q != 4'd8)) begin
            err_count_d = err_count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            x_q          <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 4'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        idx_q        <= 3'd0;
                        cnt_q        <= '0;
                        x_q          <= 3'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_count_q  <= 4'd0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= 3'd0;
                    end
                end
                RUN: begin
                    err_count_q <= err_count_d;
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        first_fail_q <= idx_q;
                    end
                    if (sample_now) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= DONE;
                            idx_q   <= 3'd0;
                            x_q     <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // Uses the updated count so a mismatch on the last vector is included.
                            pass_q  <= (err_count_d == 4'd0);
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            x_q   <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign x0         = x_q[2];
    assign x1         = x_q[1];
    assign x2         = x_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: three parameterisations, table-driven runs with a result scoreboard.
module tb_gate_vector_sequencer;

    typedef struct {
        int         u;
        int         zsel;
        logic [3:0] err;
        logic [2:0] ff;
        logic       fv;
        logic       pass;
    } vec_t;

    typedef struct {
        logic [3:0] err;
        logic [2:0] ff;
        logic       fv;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s [3];
    logic       x0_s    [3];
    logic       x1_s    [3];
    logic       x2_s    [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic       fv_s    [3];
    logic [3:0] err_s   [3];
    logic [2:0] ff_s    [3];
    logic       z0_a, z0_b, z0_c;
    logic [2:0] xv_a;
    int         zsel;

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    vec_t tbl[10];

    gate_vector_sequencer #(.DWELL(4), .EXPECTED(8'h96)) u_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .z0(z0_a),
        .x0(x0_s[0]), .x1(x1_s[0]), .x2(x2_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(err_s[0]), .fail_valid(fv_s[0]), .first_fail(ff_s[0])
    );

    gate_vector_sequencer #(.DWELL(1), .EXPECTED(8'h96)) u_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .z0(z0_b),
        .x0(x0_s[1]), .x1(x1_s[1]), .x2(x2_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(err_s[1]), .fail_valid(fv_s[1]), .first_fail(ff_s[1])
    );

    gate_vector_sequencer #(.DWELL(2), .EXPECTED(8'h00)) u_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .z0(z0_c),
        .x0(x0_s[2]), .x1(x1_s[2]), .x2(x2_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .pass(pass_s[2]), .err_count(err_s[2]), .fail_valid(fv_s[2]), .first_fail(ff_s[2])
    );

    // Gate models; xv_a is {x0,x1,x2} with x0 as MSB.
    assign xv_a = {x0_s[0], x1_s[0], x2_s[0]};
    always_comb begin
        case (zsel)
            0:       z0_a = ^xv_a;
            1:       z0_a = &xv_a;
            2:       z0_a = 1'b0;
            3:       z0_a = 1'b1;
            4:       z0_a = |xv_a;
            5:       z0_a = xv_a[2];
            6:       z0_a = xv_a[0];
            default: z0_a = ~^xv_a;
        endcase
    end
    assign z0_b = x0_s[1] ^ x1_s[1] ^ x2_s[1];
    assign z0_c = 1'b0;

    function automatic int dw(input int u);
        return (u == 0) ? 4 : (u == 1) ? 1 : 2;
    endfunction

    function automatic logic [2:0] xvec(input int u);
        return {x0_s[u], x1_s[u], x2_s[u]};
    endfunction

    function automatic logic [13:0] outs(input int u);
        return {x0_s[u], x1_s[u], x2_s[u], busy_s[u], done_s[u], pass_s[u],
                fv_s[u], err_s[u], ff_s[u]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start sampled at edge 1; observation after edge e happens on the following negedge.
    task automatic do_run(input int u, input res_t exp, input int rp_a, input int rp_b,
                          input string tag);
        int   d;
        int   busy_cnt;
        int   done_edge;
        bit   xbad;
        res_t r;
        d         = dw(u);
        busy_cnt  = 0;
        done_edge = -1;
        xbad      = 1'b0;
        @(negedge clk);
        start_s[u] = 1'b1;
        sb_q.push_back(exp);
        for (int e = 1; e <= 8 * d + 4 && done_edge < 0; e++) begin
            @(negedge clk);
            start_s[u] = ((e + 1) == rp_a) || ((e + 1) == rp_b);
            if (e == 1) begin
                check({tag, ".start_clear"}, int'(outs(u)), int'(14'b000_1000_0000_000));
            end
            if (busy_s[u]) begin
                busy_cnt++;
                if (xvec(u) != 3'((e - 1) / d)) xbad = 1'b1;
            end
            if (done_s[u]) begin
                done_edge = e;
                r = sb_q.pop_front();
                check({tag, ".err_count"}, int'(err_s[u]), int'(r.err));
                check({tag, ".first_fail"}, int'(ff_s[u]), int'(r.ff));
                check({tag, ".fail_valid"}, int'(fv_s[u]), int'(r.fv));
                check({tag, ".pass"}, int'(pass_s[u]), int'(r.pass));
                check({tag, ".done_idle"}, int'({xvec(u), busy_s[u]}), 0);
            end
        end
        start_s[u] = 1'b0;
        if (done_edge < 0 && sb_q.size() > 0) r = sb_q.pop_front();
        check({tag, ".done_edge"}, done_edge, 8 * d + 1);
        check({tag, ".busy_cycles"}, busy_cnt, 8 * d);
        check({tag, ".x_sequence_bad"}, int'(xbad), 0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        int busy34;

        tbl[0] = '{0, 0, 4'd0, 3'd0, 1'b0, 1'b1};
        tbl[1] = '{0, 1, 4'd3, 3'd1, 1'b1, 1'b0};
        tbl[2] = '{0, 2, 4'd4, 3'd1, 1'b1, 1'b0};
        tbl[3] = '{0, 3, 4'd4, 3'd0, 1'b1, 1'b0};
        tbl[4] = '{0, 4, 4'd3, 3'd3, 1'b1, 1'b0};
        tbl[5] = '{0, 5, 4'd4, 3'd1, 1'b1, 1'b0};
        tbl[6] = '{0, 6, 4'd4, 3'd2, 1'b1, 1'b0};
        tbl[7] = '{0, 7, 4'd8, 3'd0, 1'b1, 1'b0};
        tbl[8] = '{1, 0, 4'd0, 3'd0, 1'b0, 1'b1};
        tbl[9] = '{2, 0, 4'd0, 3'd0, 1'b0, 1'b1};

        zsel = 0;
        rst  = 1'b1;
        for (int u = 0; u < 3; u++) start_s[u] = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) check($sformatf("reset.u%0d", u), int'(outs(u)), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            zsel = tbl[i].zsel;
            do_run(tbl[i].u, '{tbl[i].err, tbl[i].ff, tbl[i].fv, tbl[i].pass}, 0, 0,
                   $sformatf("row%0d", i));
        end

        // Start pulses during a run must not restart or extend it.
        zsel = 0;
        do_run(0, '{4'd0, 3'd0, 1'b0, 1'b1}, 5, 20, "repulse");

        // Reset mid-run after a failing configuration, then a clean run.
        zsel = 1;
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_reset", int'(outs(0)), 0);
        @(negedge clk);
        check("reset_stays_idle", int'(outs(0)), 0);
        zsel = 0;
        do_run(0, '{4'd0, 3'd0, 1'b0, 1'b1}, 0, 0, "post_reset");

        // Start held high: done is a one-cycle pulse between back-to-back runs.
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        busy34      = 0;
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            @(negedge clk);
            if (e >= 34) start_s[0] = 1'b0;
            if (e == 34) busy34 = int'(busy_s[0]);
            if (done_s[0] && e < 66) begin
                done_cnt++;
                if (first_done < 0) first_done = e;
            end
            if (done_s[0] && e >= 66 && second_done < 0) second_done = e;
        end
        check("held.first_done", first_done, 33);
        check("held.done_width", done_cnt, 1);
        check("held.busy_restart", busy34, 1);
        check("held.second_done", second_done, 66);
        check("held.done_hold", int'({done_s[0], pass_s[0], busy_s[0]}), 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
